// File: rtl/cell4_stim_driver.sv
// -----------------------------------------------------------------------------
// cell4_stim_driver
//   Drives all 16 input vectors into a 4-input, 1-output combinational cell
//   (for example OA22: Q = (IN1|IN2)&(IN3|IN4)). The sweep runs in binary or
//   Gray order. Each vector is allowed to settle before Q is sampled and checked
//   against a truth table. The block also counts mismatches and Q toggles
//   between consecutive samples.
//
// Parameters
//   TRUTH   expected Q per vector, bit index = {IN4,IN3,IN2,IN1}
//   SETTLE  wait cycles between applying a vector and sampling Q (0 allowed)
//   PASSES  full 16-vector sweeps per run (>= 1)
//   CNT_W   width of ERR_CNT / TOG_CNT
//
// Ports
//   CLK         clock, all state on rising edge
//   RST         synchronous reset, active-high
//   START       begin a run (only honoured in IDLE)
//   MODE        0 = binary order, 1 = Gray order (latched at START)
//   IN1..IN4    registered vector driven to the cell under test
//   Q           cell output, sampled in SAMPLE
//   BUSY        high from first APPLY through last SAMPLE
//   DONE        one-cycle pulse at run end
//   PASS        ERR_CNT == 0, valid from DONE until next START
//   ERR_CNT     saturating mismatch count
//   TOG_CNT     saturating count of Q changes between consecutive samples
//   FIRST_FAIL  vector {IN4..IN1} of the first mismatch, 0 if none
// -----------------------------------------------------------------------------
module cell4_stim_driver #(
  parameter logic [15:0] TRUTH  = 16'hEEE0,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned PASSES = 1,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             MODE,
  output logic             IN1,
  output logic             IN2,
  output logic             IN3,
  output logic             IN4,
  input  logic             Q,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic [CNT_W-1:0] TOG_CNT,
  output logic [3:0]       FIRST_FAIL
);

  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [SW-1:0]    SETTLE_LAST = (SETTLE > 0) ? SW'(SETTLE - 1) : '0;
  localparam logic [PW-1:0]    PASS_LAST   = PW'(PASSES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_SAMPLE,
    S_FIN
  } state_e;

  state_e            state_q,      state_d;
  logic [3:0]        idx_q,        idx_d;
  logic [PW-1:0]     pass_q,       pass_d;
  logic [SW-1:0]     settle_q,     settle_d;
  logic              mode_q,       mode_d;
  logic [3:0]        vec_q,        vec_d;
  logic              q_prev_q,     q_prev_d;
  logic              have_prev_q,  have_prev_d;
  logic              fail_seen_q,  fail_seen_d;
  logic [CNT_W-1:0]  err_q,        err_d;
  logic [CNT_W-1:0]  tog_q,        tog_d;
  logic              ok_q,         ok_d;
  logic [3:0]        first_fail_q, first_fail_d;

  logic [3:0] vec_next;
  logic       mismatch;
  logic       toggled;

  // Step index to vector: plain binary, or reflected Gray code.
  assign vec_next = mode_q ? (idx_q ^ (idx_q >> 1)) : idx_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_d      = state_q;
    idx_d        = idx_q;
    pass_d       = pass_q;
    settle_d     = settle_q;
    mode_d       = mode_q;
    vec_d        = vec_q;
    q_prev_d     = q_prev_q;
    have_prev_d  = have_prev_q;
    fail_seen_d  = fail_seen_q;
    err_d        = err_q;
    tog_d        = tog_q;
    ok_d         = ok_q;
    first_fail_d = first_fail_q;
    // An X/Z on Q must count as a mismatch, hence the case inequality.
    mismatch     = (Q !== TRUTH[vec_q]);
    toggled      = have_prev_q && (Q != q_prev_q);

    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          err_d        = '0;
          tog_d        = '0;
          ok_d         = 1'b0;
          first_fail_d = '0;
          have_prev_d  = 1'b0;
          fail_seen_d  = 1'b0;
          mode_d       = MODE;
          idx_d        = '0;
          pass_d       = '0;
          state_d      = S_APPLY;
        end
      end

      S_APPLY: begin
        vec_d    = vec_next;
        settle_d = '0;
        state_d  = (SETTLE > 0) ? S_WAIT : S_SAMPLE;
      end

      S_WAIT: begin
        if (settle_q == SETTLE_LAST) state_d  = S_SAMPLE;
        else                         settle_d = settle_q + SW'(1);
      end

      S_SAMPLE: begin
        if (mismatch) begin
          if (err_q != CNT_MAX) err_d = err_q + CNT_W'(1);
          if (!fail_seen_q) begin
            first_fail_d = vec_q;
            fail_seen_d  = 1'b1;
          end
        end
        if (toggled && (tog_q != CNT_MAX)) tog_d = tog_q + CNT_W'(1);
        // have_prev stays set across pass boundaries, so the 15->0 wrap
        // contributes a toggle when Q differs.
        q_prev_d    = Q;
        have_prev_d = 1'b1;

        if ((idx_q == 4'hF) && (pass_q == PASS_LAST)) begin
          // PASS uses the post-sample count so it is valid during FIN.
          ok_d    = (err_d == '0);
          state_d = S_FIN;
        end else begin
          idx_d   = idx_q + 4'd1;
          if (idx_q == 4'hF) pass_d = pass_q + PW'(1);
          state_d = S_APPLY;
        end
      end

      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of the others, independent of order.
    if (RST) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      pass_q       <= '0;
      settle_q     <= '0;
      mode_q       <= 1'b0;
      vec_q        <= '0;
      q_prev_q     <= 1'b0;
      have_prev_q  <= 1'b0;
      fail_seen_q  <= 1'b0;
      err_q        <= '0;
      tog_q        <= '0;
      ok_q         <= 1'b0;
      first_fail_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pass_q       <= pass_d;
      settle_q     <= settle_d;
      mode_q       <= mode_d;
      vec_q        <= vec_d;
      q_prev_q     <= q_prev_d;
      have_prev_q  <= have_prev_d;
      fail_seen_q  <= fail_seen_d;
      err_q        <= err_d;
      tog_q        <= tog_d;
      ok_q         <= ok_d;
      first_fail_q <= first_fail_d;
    end
  end

  assign {IN4, IN3, IN2, IN1} = vec_q;
  assign BUSY       = (state_q == S_APPLY) || (state_q == S_WAIT) || (state_q == S_SAMPLE);
  assign DONE       = (state_q == S_FIN);
  assign PASS       = ok_q;
  assign ERR_CNT    = err_q;
  assign TOG_CNT    = tog_q;
  assign FIRST_FAIL = first_fail_q;

endmodule
